baccarat_sequencer: RTL
=======================

# baccarat_sequencer

Moore state machine that sequences the baccarat card datapath for one round per reset. Drives the six card-register load strobes in dealing order, applies the natural, player-third-card and banker-third-card rules to the datapath's score and third-card outputs, and lights the win indicators. Sits between the board's slow clock/reset inputs and the datapath.

## Interface
Parameters:
- none.

Ports:
- `slow_clock` in 1: the single clock; state register updates on its rising edge. Reset is asynchronous and active-low.
- `resetb` in 1: asynchronous, active-low reset; forces the start state.
- `pcard3_out` in 4: player third-card rank from the datapath (0 = no card, 1–13 = A..K).
- `pscore_out` in 4: player hand total, 0–9.
- `dscore_out` in 4: dealer hand total, 0–9.
- `load_pcard1`, `load_pcard2`, `load_pcard3` out 1 each: player card-register load strobes.
- `load_dcard1`, `load_dcard2`, `load_dcard3` out 1 each: dealer card-register load strobes.
- `player_win_light` out 1: player has won, or the round is a tie.
- `dealer_win_light` out 1: dealer has won, or the round is a tie.

## Operation
- States:
  - S_P1, S_D1, S_P2, S_D2: deal the first four cards.
  - S_EVAL: first decision point.
  - S_P3: player draws a third card.
  - S_EVAL_D: banker decision after the player's third card.
  - S_D3: dealer draws a third card.
  - S_DONE: result held.
- Reset state is S_P1. While `resetb` = 0, all outputs are 0 (loads are gated by `resetb`).
- Outputs are Moore-decoded from state. Exactly one load is high in S_P1, S_D1, S_P2, S_D2, S_P3 and S_D3 (the matching strobe). No load is high in S_EVAL, S_EVAL_D or S_DONE.
- Transitions:
  - S_P1 → S_D1 → S_P2 → S_D2 → S_EVAL, unconditionally.
  - S_EVAL, natural: if `pscore_out` ≥ 8 or `dscore_out` ≥ 8 → S_DONE.
  - S_EVAL, player draws: else if `pscore_out` ≤ 5 → S_P3.
  - S_EVAL, player stands (6/7): `dscore_out` ≤ 5 → S_D3; otherwise → S_DONE.
  - S_P3 → S_EVAL_D.
  - S_EVAL_D, banker rule with v = third-card value (`pcard3_out` if ≤ 9, else 0):
    - dscore 0–2 draws.
    - dscore 3 draws if v ≠ 8.
    - dscore 4 draws if v in 2..7.
    - dscore 5 draws if v in 4..7.
    - dscore 6 draws if v in 6..7.
    - dscore 7–9 stands.
    - Draw → S_D3; stand → S_DONE.
  - S_D3 → S_DONE.
  - S_DONE is absorbing until reset.
- Lights, combinational in S_DONE only:
  - `pscore_out` > `dscore_out`: player light only.
  - `pscore_out` < `dscore_out`: dealer light only.
  - Equal: both lights.
  - Outside S_DONE: both 0.
- Score inputs are compared unsigned on 4 bits. Values 10–15 are illegal; the only requirement is that the FSM still reaches S_DONE.
- `pcard3_out` values 14–15 are treated as v = 0.

## Timing
- Datapath registers sample on the falling edge of `slow_clock`. Each load is high for a full state cycle, so it is captured mid-cycle.
- Updated scores are stable before the next rising edge, where S_EVAL and S_EVAL_D decide.
- Cycle 0 is the first rising edge after `resetb` rises (the FSM is already in S_P1 during cycle 0). S_DONE is reached at cycle:
  - 5 for a natural, or when both hands stand.
  - 6 when only the dealer draws (path S_EVAL → S_D3).
  - 7 when the player draws and the banker stands.
  - 8 when both draw.
- Reset mid-round: the FSM returns to S_P1 asynchronously, and all outputs drop to 0 in the same instant.
- No handshake; the FSM does not stall.

## Configuration
- `BACCARAT_STATE_TRACE_EN`:
  - Defined: adds output `state_out` [3:0], the registered state encoding, for HEX/LED debug.
  - Undefined: the port is absent and behaviour is otherwise identical.

## Structure
- `baccarat_pkg` holds:
  - the `state_t` enum (4-bit encoding: S_P1 = 0 … S_DONE = 8);
  - the `card_value` function (rank → 0–9);
  - the constants `NATURAL_MIN` = 8 and `DRAW_MAX` = 5.
- Sub-module `banker_rule`, combinational: inputs `dscore`, `pcard3`; output `dealer_draws`.
  - Instantiated for the S_EVAL_D decision.
  - Unit-tested separately across all 10×14 input combinations.

## Test plan
- Natural: pscore = 8, dscore = 3 at S_EVAL → S_DONE at cycle 5, player light = 1, dealer light = 0, no third-card loads ever asserted.
- Both stand: pscore = 6, dscore = 7 → no third loads, dealer light only at cycle 5. Tie variant 7/7 → both lights.
- Dealer-only draw: pscore = 7, dscore = 4 → `load_dcard3` high in cycle 5, S_DONE at cycle 6; final dscore = 9 → dealer light.
- Banker rule with a face card: pscore = 2, pcard3 = 12 (v = 0), dscore = 3 → `load_pcard3` in cycle 5, `load_dcard3` in cycle 7, S_DONE at cycle 8.
- Banker rule, stand: pcard3 = 8, dscore = 3 → banker stands, S_DONE at cycle 7. Sweep dscore 4–6 at v boundaries (1/2, 3/4, 5/6, 7/8).
- Async reset in S_P3: drop `resetb` mid-cycle → all outputs 0 immediately. Release → `load_pcard1` high in cycle 0 and the full sequence repeats.

Source files
------------

// File: rtl/baccarat_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
// Shared types and helpers for the baccarat round sequencer.
//   state_t     : FSM state encoding (S_P1 = 0 ... S_DONE = 8), 4 bits wide.
//   card_value  : maps a card rank (0 = none, 1..13 = A..K) to its 0..9 value.
//   NATURAL_MIN : a two-card total at or above this ends the round at once.
//   DRAW_MAX    : a total at or below this draws a third card.
// Related build option: BACCARAT_STATE_TRACE_EN (see baccarat_sequencer).
// -----------------------------------------------------------------------------
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_P1     = 4'd0,
    S_D1     = 4'd1,
    S_P2     = 4'd2,
    S_D2     = 4'd3,
    S_EVAL   = 4'd4,
    S_P3     = 4'd5,
    S_EVAL_D = 4'd6,
    S_D3     = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  localparam logic [3:0] NATURAL_MIN = 4'd8;
  localparam logic [3:0] DRAW_MAX    = 4'd5;

  // Tens and face cards count zero; ranks 14..15 are not real cards and also count zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    if (rank <= 4'd9) begin
      return rank;
    end else begin
      return 4'd0;
    end
  endfunction

endpackage

// File: rtl/baccarat_sequencer_banker_rule.sv
// -----------------------------------------------------------------------------
// banker_rule
// Combinational banker third-card decision, used after the player has drawn.
// Ports:
//   dscore       in  4 : banker two-card total (0..9; 10..15 treated as stand)
//   pcard3       in  4 : player third-card rank (converted to its 0..9 value)
//   dealer_draws out 1 : 1 when the banker must take a third card
// -----------------------------------------------------------------------------
module banker_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       dealer_draws
);

  logic [3:0] v;

  assign v = card_value(pcard3);

  // Banker drawing table indexed by banker total, qualified by the player's third-card value.
  always_comb begin
    dealer_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
      4'd3:             dealer_draws = (v != 4'd8);
      4'd4:             dealer_draws = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             dealer_draws = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             dealer_draws = (v >= 4'd6) && (v <= 4'd7);
      // 7..9 stand; illegal totals also stand so the round still finishes.
      default:          dealer_draws = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_sequencer.sv
// -----------------------------------------------------------------------------
// baccarat_sequencer
// Moore FSM that runs one baccarat round per reset: strobes the six card
// register loads in dealing order, applies the natural / player / banker
// third-card rules to the datapath scores and lights the win indicators.
// Ports:
//   slow_clock        in  1 : clock, state advances on the rising edge
//   resetb            in  1 : asynchronous active-low reset, forces S_P1
//   pcard3_out        in  4 : player third-card rank from the datapath
//   pscore_out        in  4 : player total 0..9
//   dscore_out        in  4 : dealer total 0..9
//   load_pcard1..3    out 1 : player card-register load strobes
//   load_dcard1..3    out 1 : dealer card-register load strobes
//   player_win_light  out 1 : player won, or tie
//   dealer_win_light  out 1 : dealer won, or tie
//   state_out         out 4 : registered state (only with BACCARAT_STATE_TRACE_EN)
// Build option: BACCARAT_STATE_TRACE_EN adds the state_out debug port.
// -----------------------------------------------------------------------------
module baccarat_sequencer
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pcard3_out,
  input  logic [3:0] pscore_out,
  input  logic [3:0] dscore_out,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
`ifdef BACCARAT_STATE_TRACE_EN
  ,
  output logic [3:0] state_out
`endif
);

  // One-hot load vector bit order: {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3}.
  localparam logic [5:0] LOAD_P1   = 6'b100000;
  localparam logic [5:0] LOAD_D1   = 6'b010000;
  localparam logic [5:0] LOAD_P2   = 6'b001000;
  localparam logic [5:0] LOAD_D2   = 6'b000100;
  localparam logic [5:0] LOAD_P3   = 6'b000010;
  localparam logic [5:0] LOAD_D3   = 6'b000001;
  localparam logic [5:0] LOAD_NONE = 6'b000000;

  state_t     state_q, state_d;
  logic [5:0] load_q, load_d;
  logic       dealer_draws;
  logic       round_done;

  banker_rule u_banker_rule (
    .dscore      (dscore_out),
    .pcard3      (pcard3_out),
    .dealer_draws(dealer_draws)
  );

  // Next-state logic: fixed deal order, then the two decision points.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_P1:     state_d = S_D1;
      S_D1:     state_d = S_P2;
      S_P2:     state_d = S_D2;
      S_D2:     state_d = S_EVAL;
      S_EVAL: begin
        if ((pscore_out >= NATURAL_MIN) || (dscore_out >= NATURAL_MIN)) begin
          state_d = S_DONE;
        end else if (pscore_out <= DRAW_MAX) begin
          state_d = S_P3;
        end else if (dscore_out <= DRAW_MAX) begin
          state_d = S_D3;
        end else begin
          state_d = S_DONE;
        end
      end
      S_P3:     state_d = S_EVAL_D;
      S_EVAL_D: begin
        if (dealer_draws) begin
          state_d = S_D3;
        end else begin
          state_d = S_DONE;
        end
      end
      S_D3:     state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_P1;
    endcase
  end

  // Load strobes decoded from the next state so they come straight out of flops.
  always_comb begin
    load_d = LOAD_NONE;
    case (state_d)
      S_P1:    load_d = LOAD_P1;
      S_D1:    load_d = LOAD_D1;
      S_P2:    load_d = LOAD_P2;
      S_D2:    load_d = LOAD_D2;
      S_P3:    load_d = LOAD_P3;
      S_D3:    load_d = LOAD_D3;
      default: load_d = LOAD_NONE;
    endcase
  end

  // State and registered load strobes; reset lands in S_P1 with its strobe armed.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_P1;
      load_q  <= LOAD_P1;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

  // Gating with resetb keeps every output low while reset is held, even though
  // the reset state itself would otherwise show the first load strobe.
  assign load_pcard1 = load_q[5] & resetb;
  assign load_dcard1 = load_q[4] & resetb;
  assign load_pcard2 = load_q[3] & resetb;
  assign load_dcard2 = load_q[2] & resetb;
  assign load_pcard3 = load_q[1] & resetb;
  assign load_dcard3 = load_q[0] & resetb;

  assign round_done       = (state_q == S_DONE) & resetb;
  assign player_win_light = round_done & (pscore_out >= dscore_out);
  assign dealer_win_light = round_done & (dscore_out >= pscore_out);

`ifdef BACCARAT_STATE_TRACE_EN
  assign state_out = state_q;
`endif

endmodule
